// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the CPU-side RAM access controller: transfer lengths,
// error codes, FSM states and the alignment rule.
package mem_ctrl_defs;

  localparam logic [1:0] LEN_BYTE  = 2'b00;
  localparam logic [1:0] LEN_HALF  = 2'b01;
  localparam logic [1:0] LEN_WORD  = 2'b10;
  localparam logic [1:0] LEN_DWORD = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // An item must sit on a boundary equal to its own size.
  function automatic logic is_misaligned(input logic [1:0] len, input logic [2:0] addr_lo);
    logic r;
    case (len)
      LEN_HALF:  r = addr_lo[0];
      LEN_WORD:  r = |addr_lo[1:0];
      LEN_DWORD: r = |addr_lo[2:0];
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Alignment check of a latched request and sign/zero extension of the
// right-aligned RAM item into the 64-bit load result.
module mem_load_ext
  import mem_ctrl_defs::*;
(
  input  logic [1:0]  i_len,
  input  logic        i_signed,
  input  logic [2:0]  i_addr_lo,
  input  logic [31:0] i_item,
  output logic        o_misaligned,
  output logic [63:0] o_ext
);

  logic w_fill;

  assign o_misaligned = is_misaligned(i_len, i_addr_lo);

  always_comb begin
    w_fill = 1'b0;
    o_ext  = 64'd0;
    case (i_len)
      LEN_BYTE: begin
        w_fill = i_signed & i_item[7];
        o_ext  = {{56{w_fill}}, i_item[7:0]};
      end
      LEN_HALF: begin
        w_fill = i_signed & i_item[15];
        o_ext  = {{48{w_fill}}, i_item[15:0]};
      end
      default: begin
        w_fill = i_signed & i_item[31];
        o_ext  = {{32{w_fill}}, i_item};
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side initiator for the RAM enable/mfc handshake: one load/store at a time,
// doublewords split into two big-endian word transfers, with mfc timeout.
module mem_access_ctrl
  import mem_ctrl_defs::*;
#(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              req_rw,
  input  logic [1:0]        req_len,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [63:0]       rdata,
  output logic              mem_enable,
  output logic              mem_read_write,
  output logic [1:0]        mem_data_length,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_mfc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_rw;
  logic [1:0]          r_len;
  logic                r_signed;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_wdata;
  logic                r_second;
  logic [1:0]          r_err;
  logic [31:0]         r_hi;
  logic [31:0]         r_lo;
  logic [63:0]         r_rdata;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_misaligned;
  logic [63:0]         w_ext;
  logic                w_dword;
  logic                w_first_half;
  logic                w_tmo;
  logic                w_xfer;

  assign w_dword      = (r_len == LEN_DWORD);
  assign w_first_half = w_dword & ~r_second;
  assign w_tmo        = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_xfer       = (r_state == ST_SETUP) || (r_state == ST_ACCESS) || (r_state == ST_RELEASE);

  mem_load_ext u_ext (
    .i_len        (r_len),
    .i_signed     (r_signed),
    .i_addr_lo    (r_addr[2:0]),
    .i_item       (r_lo),
    .o_misaligned (w_misaligned),
    .o_ext        (w_ext)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (req) w_next = ST_CHECK;
      ST_CHECK:   w_next = w_misaligned ? ST_DONE : ST_SETUP;
      ST_SETUP:   w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (mem_mfc)    w_next = ST_RELEASE;
        else if (w_tmo) w_next = ST_DONE;
      end
      ST_RELEASE: begin
        if (!mem_mfc)   w_next = w_first_half ? ST_SETUP : ST_DONE;
        else if (w_tmo) w_next = ST_DONE;
      end
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rw     <= 1'b0;
      r_len    <= LEN_BYTE;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 64'd0;
      r_second <= 1'b0;
      r_err    <= ERR_NONE;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_rdata  <= 64'd0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_rw     <= req_rw;
            r_len    <= req_len;
            r_signed <= req_signed;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_second <= 1'b0;
            r_err    <= ERR_NONE;
          end
        end
        ST_CHECK: if (w_misaligned) r_err <= ERR_ALIGN;
        ST_SETUP: r_cnt <= '0;
        ST_ACCESS: begin
          if (mem_mfc) begin
            r_cnt <= '0;
            if (r_rw) begin
              if (w_first_half) r_hi <= mem_rdata;
              else              r_lo <= mem_rdata;
            end
          end else if (w_tmo) begin
            r_err <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          // The load result is committed only once the whole request succeeds,
          // so a timeout on the second half leaves rdata untouched.
          if (!mem_mfc) begin
            if (w_first_half) begin
              r_second <= 1'b1;
            end else if (r_rw) begin
              r_rdata <= w_dword ? {r_hi, r_lo} : w_ext;
            end
          end else if (w_tmo) begin
            r_err <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (r_state != ST_IDLE);
    done            = (r_state == ST_DONE);
    err             = done && (r_err != ERR_NONE);
    err_code        = done ? r_err : ERR_NONE;
    rdata           = r_rdata;
    mem_enable      = (r_state == ST_ACCESS);
    mem_read_write  = w_xfer & r_rw;
    mem_data_length = LEN_BYTE;
    mem_address     = '0;
    mem_wdata       = 32'd0;
    if (w_xfer) begin
      mem_data_length = w_dword ? LEN_WORD : r_len;
      mem_address     = r_addr + ADDR_W'({r_second, 2'b00});
      if (w_dword) mem_wdata = r_second ? r_wdata[31:0] : r_wdata[63:32];
      else         mem_wdata = r_wdata[31:0];
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl against a big-endian behavioural RAM
// that raises mfc in the second enable cycle and drops it after enable falls.
module tb_mem_access_ctrl;

  localparam int ADDR_W  = 9;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic              req_rw;
  logic [1:0]        req_len;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [63:0]       rdata;
  logic              mem_enable, mem_read_write;
  logic [1:0]        mem_data_length;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_mfc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .req             (req),
    .req_rw          (req_rw),
    .req_len         (req_len),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_code        (err_code),
    .rdata           (rdata),
    .mem_enable      (mem_enable),
    .mem_read_write  (mem_read_write),
    .mem_data_length (mem_data_length),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_mfc         (mem_mfc)
  );

  // Behavioural RAM
  logic [7:0] ram [0:511];
  logic       mfc_on;
  int         ecnt;

  always @(posedge clk) begin
    if (reset) begin
      mem_mfc   <= 1'b0;
      mem_rdata <= 32'd0;
      ecnt      <= 0;
    end else if (!mem_enable) begin
      ecnt <= 0;
      if (mem_mfc) mem_mfc <= 1'b0;
    end else begin
      ecnt <= ecnt + 1;
      if (ecnt == 0 && mfc_on) begin
        mem_mfc <= 1'b1;
        if (mem_read_write) begin
          case (mem_data_length)
            2'b00:   mem_rdata <= {24'd0, ram[mem_address]};
            2'b01:   mem_rdata <= {16'd0, ram[mem_address], ram[mem_address + 9'd1]};
            default: mem_rdata <= {ram[mem_address], ram[mem_address + 9'd1],
                                   ram[mem_address + 9'd2], ram[mem_address + 9'd3]};
          endcase
        end else begin
          case (mem_data_length)
            2'b00: ram[mem_address] = mem_wdata[7:0];
            2'b01: begin
              ram[mem_address]        = mem_wdata[15:8];
              ram[mem_address + 9'd1] = mem_wdata[7:0];
            end
            default: begin
              ram[mem_address]        = mem_wdata[31:24];
              ram[mem_address + 9'd1] = mem_wdata[23:16];
              ram[mem_address + 9'd2] = mem_wdata[15:8];
              ram[mem_address + 9'd3] = mem_wdata[7:0];
            end
          endcase
        end
      end
    end
  end

  // Enable-pulse monitor
  logic              prev_en = 1'b0;
  int                en_cycles = 0;
  int                n_pulses = 0;
  logic [ADDR_W-1:0] p_addr [0:15];
  logic [31:0]       p_data [0:15];

  always @(posedge clk) begin
    prev_en <= mem_enable;
    if (mem_enable) en_cycles <= en_cycles + 1;
    if (mem_enable && !prev_en) begin
      p_addr[n_pulses % 16] <= mem_address;
      p_data[n_pulses % 16] <= mem_wdata;
      n_pulses <= n_pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns the edge count (accepting edge included)
  // until done is seen, plus the number of enable cycles it took.
  task automatic run_req(input logic rw, input logic [1:0] len, input logic sgn,
                         input logic [ADDR_W-1:0] addr, input logic [63:0] wd,
                         output int edges, output int encyc);
    int c0;
    @(negedge clk);
    req = 1'b1; req_rw = rw; req_len = len; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    c0 = en_cycles;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    req = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!done) chk("wait_done", {63'd0, done}, 64'd1);
    encyc = en_cycles - c0;
  endtask

  int edges, encyc, p0, wait_n;

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[3] = 8'h80;
    mfc_on = 1'b1;
    reset = 1'b1; req = 1'b0; req_rw = 1'b0; req_len = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = 64'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_enable", {63'd0, mem_enable}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_addr", {55'd0, mem_address}, 64'd0);
    reset = 1'b0;

    // Word write then read at 8
    p0 = n_pulses;
    run_req(1'b0, 2'b10, 1'b0, 9'd8, 64'h00000000DEADBEEF, edges, encyc);
    chk("ww_err", {63'd0, err}, 64'd0);
    chk("ww_edges", 64'(edges), 64'd7);
    chk("ww_encyc", 64'(encyc), 64'd2);
    chk("ww_paddr", {55'd0, p_addr[p0 % 16]}, 64'd8);
    chk("ww_pdata", {32'd0, p_data[p0 % 16]}, 64'h00000000DEADBEEF);
    run_req(1'b1, 2'b10, 1'b0, 9'd8, 64'd0, edges, encyc);
    chk("wr_rdata", rdata, 64'h00000000DEADBEEF);
    chk("wr_err", {62'd0, err, err_code != 2'b00}, 64'd0);
    chk("wr_encyc", 64'(encyc), 64'd2);

    // Byte loads at 3, signed and unsigned
    run_req(1'b1, 2'b00, 1'b1, 9'd3, 64'd0, edges, encyc);
    chk("sb_rdata", rdata, 64'hFFFFFFFFFFFFFF80);
    run_req(1'b1, 2'b00, 1'b0, 9'd3, 64'd0, edges, encyc);
    chk("ub_rdata", rdata, 64'h0000000000000080);

    // Doubleword write then read at 16
    p0 = n_pulses;
    run_req(1'b0, 2'b11, 1'b0, 9'd16, 64'h0123456789ABCDEF, edges, encyc);
    chk("dw_edges", 64'(edges), 64'd12);
    chk("dw_pulses", 64'(n_pulses - p0), 64'd2);
    chk("dw_addr0", {55'd0, p_addr[p0 % 16]}, 64'd16);
    chk("dw_data0", {32'd0, p_data[p0 % 16]}, 64'h0000000001234567);
    chk("dw_addr1", {55'd0, p_addr[(p0 + 1) % 16]}, 64'd20);
    chk("dw_data1", {32'd0, p_data[(p0 + 1) % 16]}, 64'h0000000089ABCDEF);
    run_req(1'b1, 2'b11, 1'b0, 9'd16, 64'd0, edges, encyc);
    chk("dr_rdata", rdata, 64'h0123456789ABCDEF);
    chk("dr_encyc", 64'(encyc), 64'd4);

    // Halfword and byte loads out of the stored doubleword
    run_req(1'b1, 2'b01, 1'b1, 9'd20, 64'd0, edges, encyc);
    chk("sh_rdata", rdata, 64'hFFFFFFFFFFFF89AB);
    run_req(1'b1, 2'b00, 1'b1, 9'd17, 64'd0, edges, encyc);
    chk("sb17_rdata", rdata, 64'h0000000000000023);

    // Misaligned halfword at 5
    run_req(1'b1, 2'b01, 1'b0, 9'd5, 64'd0, edges, encyc);
    chk("mis_err", {63'd0, err}, 64'd1);
    chk("mis_code", {62'd0, err_code}, 64'd1);
    chk("mis_edges", 64'(edges), 64'd2);
    chk("mis_encyc", 64'(encyc), 64'd0);
    chk("mis_rdata", rdata, 64'h0000000000000023);

    // Timeout: mfc never rises
    mfc_on = 1'b0;
    run_req(1'b1, 2'b10, 1'b0, 9'd8, 64'd0, edges, encyc);
    chk("tmo_err", {63'd0, err}, 64'd1);
    chk("tmo_code", {62'd0, err_code}, 64'd2);
    chk("tmo_enable", {63'd0, mem_enable}, 64'd0);
    chk("tmo_encyc", 64'(encyc), 64'd15);
    chk("tmo_edges", 64'(edges), 64'd18);
    chk("tmo_rdata", rdata, 64'h0000000000000023);
    mfc_on = 1'b1;

    // Reset in the middle of ACCESS
    @(negedge clk);
    req = 1'b1; req_rw = 1'b1; req_len = 2'b10; req_signed = 1'b0; req_addr = 9'd8;
    @(negedge clk);
    req = 1'b0;
    wait_n = 0;
    while (!mem_enable && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    chk("rst_mid_reached", {63'd0, mem_enable}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_enable", {63'd0, mem_enable}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_rdata", rdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_req(1'b1, 2'b10, 1'b0, 9'd8, 64'd0, edges, encyc);
    chk("post_rst_rdata", rdata, 64'h00000000DEADBEEF);
    chk("post_rst_err", {63'd0, err}, 64'd0);
    chk("post_rst_edges", 64'(edges), 64'd7);

    @(negedge clk);
    chk("final_idle", {63'd0, busy}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the RAM's enable/read_write/data_length/address/data_in/data_out/mfc handshake.
- Accepts one load/store request from the datapath and checks its alignment.
- Sequences the RAM handshake, waits for mfc, and sign- or zero-extends load data.
- Splits doubleword accesses into two word transfers, and reports misalignment and mfc timeout to the control unit.

Parameters:
- TIMEOUT, 15: maximum cycles to wait for an mfc edge before aborting.
- ADDR_W, 9: address width; matches the RAM.

Ports:
- clk in 1: system clock, rising edge.
- reset in 1: asynchronous, active-high reset.
- req in 1: request strobe; sampled only when busy=0.
- req_rw in 1: 1 = read (load), 0 = write (store); same encoding as the RAM read_write.
- req_len in 2: 00 byte, 01 halfword, 10 word, 11 doubleword.
- req_signed in 1: sign-extend load data when 1.
- req_addr in ADDR_W: byte address.
- req_wdata in 64: store data, right-aligned.
- busy out 1: request in progress.
- done out 1: one-cycle completion pulse.
- err out 1: qualifies done; the request failed.
- err_code out 2: 00 none, 01 misaligned, 10 timeout.
- rdata out 64: load result; valid with done, held until the next accept.
- mem_enable out 1: RAM enable.
- mem_read_write out 1: RAM read_write.
- mem_data_length out 2: RAM data_length (never 11 on the RAM side).
- mem_address out ADDR_W: RAM address.
- mem_wdata out 32: to the RAM data_in.
- mem_rdata in 32: from the RAM data_out; item right-aligned.
- mem_mfc in 1: memory function complete.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0, including mem_enable.
  - Reset mid-transfer drops mem_enable in the same cycle and loses the request.
- States and transitions:
  - IDLE: on req=1 with busy=0, latch all req_* fields, go to CHECK.
  - CHECK: misaligned if any of the following hold:
    - halfword with addr[0]=1;
    - word with addr[1:0]≠0;
    - doubleword with addr[2:0]≠0.
    - Misaligned → DONE with err=1, err_code=01; no RAM activity.
    - Otherwise → SETUP.
  - SETUP (1 cycle): drive mem_address, mem_data_length, mem_read_write, mem_wdata with mem_enable=0 (setup cycle). Go to ACCESS.
  - ACCESS: mem_enable=1 and all RAM-side signals stable.
    - On mem_mfc=1 → RELEASE; capture mem_rdata on reads.
    - If the timeout counter reaches TIMEOUT → DONE with err code 10.
  - RELEASE: mem_enable=0; wait for mem_mfc=0. Timeout counted here as well.
    - If mem_mfc=0, doubleword, and first half → SETUP with address+4.
    - If mem_mfc=0 otherwise → DONE.
  - DONE (1 cycle): done=1; err/err_code per outcome. Go to IDLE.
- busy: 1 in every state except IDLE.
  - req while busy is ignored, not queued.
  - req in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- Doubleword handling:
  - Two word transfers; the lower address carries bits [63:32] (big-endian).
  - Aligned addresses make address+4 ≤ 508, so no wrap is possible.
- Load extension (byte/half/word):
  - rdata = mem_rdata item extended to 64 bits.
  - Sign-extended from bit 7/15/31 when req_signed=1; zero-extended otherwise.
- Store data: mem_wdata = req_wdata[31:0] for byte/half/word; the RAM ignores unused upper bits.
- Timeout counter:
  - Clears on entry to ACCESS and to RELEASE; increments each cycle in those states.
  - If mfc and timeout land in the same cycle, mfc wins.
  - After a timeout mem_enable is 0 and rdata keeps its previous value.
- Latency:
  - Minimum: done is high in the cycle after the 4th rising edge following acceptance (CHECK, SETUP, ACCESS, RELEASE, then DONE, each 1 cycle).
  - Each extra mfc wait cycle adds 1 cycle; a doubleword adds SETUP+ACCESS+RELEASE.
  - A misaligned request asserts done 2 edges after acceptance.

Decomposition:
- Package mem_ctrl_defs:
  - length codes LEN_BYTE, LEN_HALF, LEN_WORD, LEN_DWORD;
  - ERR_NONE, ERR_ALIGN, ERR_TIMEOUT;
  - state encodings.
- Sub-module mem_load_ext: combinational alignment check plus load sign/zero extension.
- The FSM and counters stay in mem_access_ctrl.

Test Plan:
- Word write then read, using a behavioural RAM model that asserts mfc 2 cycles after enable and drops it 1 cycle after enable falls:
  - write addr 9'd8, data 32'hDEADBEEF; then read addr 8;
  - expect rdata=64'h00000000DEADBEEF, err=0;
  - expect mem_enable held for exactly 2 ACCESS cycles.
- Signed byte load: RAM holds 8'h80 at addr 3, read with req_signed=1 → rdata=64'hFFFFFFFFFFFFFF80. Same read with req_signed=0 → 64'h80.
- Doubleword write then read at addr 16, wdata 64'h0123456789ABCDEF:
  - two enable pulses, at addresses 16 then 20, with data 32'h01234567 then 32'h89ABCDEF;
  - read returns the same 64-bit value.
- Misaligned halfword at addr 5:
  - done with err=1, err_code=01, 2 edges after accept;
  - mem_enable never asserted.
- Timeout: model never raises mfc → done with err_code=10 after TIMEOUT=15 ACCESS cycles, and mem_enable=0 in the DONE cycle.
- Reset mid-ACCESS: assert reset between clock edges → mem_enable and busy fall immediately; after release, a new word read completes normally.
